// File: rtl/data_memory_pkg.sv
// Shared types and constants for the synchronous data memory.
// The latency helper keeps an out-of-range READ_LATENCY from building a broken pipeline.
package data_memory_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    localparam int READ_LATENCY_MIN = 1;
    localparam int READ_LATENCY_MAX = 3;

    function automatic int clamp_latency(input int lat);
        if (lat < READ_LATENCY_MIN) return READ_LATENCY_MIN;
        if (lat > READ_LATENCY_MAX) return READ_LATENCY_MAX;
        return lat;
    endfunction

endpackage

// File: rtl/tristate_driver.sv
// Drives a bus with din while en is high, otherwise releases it to Z.
module tristate_driver #(
    parameter int W = 8
) (
    input  logic         en,
    input  logic [W-1:0] din,
    output tri   [W-1:0] dout
);

    assign dout = en ? din : {W{1'bz}};

endmodule

// File: rtl/data_memory_sync.sv
// Single-port data memory with a CPU request port, a debug back door that owns the
// array while enabled, a fixed-latency read pipeline and an optional post-reset clear sweep.
module data_memory_sync
    import data_memory_pkg::*;
#(
    parameter int D_ADDR_W       = 12,
    parameter int DATA_W         = 8,
    parameter int D_MEMORY_DEPTH = 1 << D_ADDR_W,
    parameter int READ_LATENCY   = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [D_ADDR_W-1:0] data_addr,
    input  logic                write_enable,
    input  logic [DATA_W-1:0]   write_data,
    input  logic                output_enable,
    output tri   [DATA_W-1:0]   read_data,
    output logic                read_valid,
    input  logic                debug_enable,
    input  logic [D_ADDR_W-1:0] debug_addr,
    input  logic                debug_we,
    input  logic [DATA_W-1:0]   debug_wdata,
    output logic [DATA_W-1:0]   debug_rdata,
    output logic                init_done
);

    localparam int                  LAT         = clamp_latency(READ_LATENCY);
    localparam state_e              RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
    localparam logic [D_ADDR_W-1:0] LAST_ADDR   = D_ADDR_W'(D_MEMORY_DEPTH - 1);

    logic [DATA_W-1:0] mem [D_MEMORY_DEPTH];

    state_e                       state_q, state_d;
    logic [D_ADDR_W-1:0]          clear_cnt_q, clear_cnt_d;
    logic [LAT:1]                 vld_pipe_q, vld_pipe_d;
    logic [LAT:1][DATA_W-1:0]     rd_pipe_q, rd_pipe_d;
    logic [DATA_W-1:0]            debug_rdata_q, debug_rdata_d;

    logic                         mem_we;
    logic [D_ADDR_W-1:0]          mem_waddr;
    logic [DATA_W-1:0]            mem_wdata;
    logic                         run, accept, cpu_in_range, dbg_in_range;

    function automatic logic in_range(input logic [D_ADDR_W-1:0] a);
        return 32'(a) < 32'(D_MEMORY_DEPTH);
    endfunction

    // Gated by rst_n so the handshake drops the instant reset asserts, even with no sweep.
    assign run          = (state_q == ST_RUN);
    assign req_ready    = rst_n && run && !debug_enable;
    assign init_done    = rst_n && run;
    assign accept       = req_valid && req_ready;
    assign cpu_in_range = in_range(data_addr);
    assign dbg_in_range = in_range(debug_addr);

    always_comb begin
        state_d       = state_q;
        clear_cnt_d   = clear_cnt_q;
        debug_rdata_d = debug_rdata_q;
        mem_we        = 1'b0;
        mem_waddr     = data_addr;
        mem_wdata     = write_data;
        vld_pipe_d    = '0;
        rd_pipe_d     = '0;

        // Stage 1 samples the array before this edge's write; writes from the prior
        // cycle are already committed, so read-after-write never sees stale data.
        vld_pipe_d[1] = accept && !write_enable && output_enable;
        rd_pipe_d[1]  = cpu_in_range ? mem[data_addr] : '0;
        for (int i = 2; i <= LAT; i++) begin
            vld_pipe_d[i] = vld_pipe_q[i-1];
            rd_pipe_d[i]  = rd_pipe_q[i-1];
        end

        case (state_q)
            ST_CLEAR: begin
                mem_we        = 1'b1;
                mem_waddr     = clear_cnt_q;
                mem_wdata     = '0;
                debug_rdata_d = '0;
                clear_cnt_d   = clear_cnt_q + 1'b1;
                if (clear_cnt_q == LAST_ADDR) begin
                    state_d     = ST_RUN;
                    clear_cnt_d = '0;
                end
            end
            ST_RUN: begin
                if (debug_enable) begin
                    mem_we        = debug_we && dbg_in_range;
                    mem_waddr     = debug_addr;
                    mem_wdata     = debug_wdata;
                    debug_rdata_d = dbg_in_range ? mem[debug_addr] : '0;
                end else begin
                    mem_we = accept && write_enable && cpu_in_range;
                end
            end
            default: state_d = RESET_STATE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= RESET_STATE;
            clear_cnt_q   <= '0;
            vld_pipe_q    <= '0;
            rd_pipe_q     <= '0;
            debug_rdata_q <= '0;
        end else begin
            state_q       <= state_d;
            clear_cnt_q   <= clear_cnt_d;
            vld_pipe_q    <= vld_pipe_d;
            rd_pipe_q     <= rd_pipe_d;
            debug_rdata_q <= debug_rdata_d;
        end
    end

    // Array contents survive reset; only the sweep zeroes them.
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

    assign read_valid  = vld_pipe_q[LAT];
    assign debug_rdata = debug_rdata_q;

    tristate_driver #(
        .W(DATA_W)
    ) u_rd_drv (
        .en  (vld_pipe_q[LAT]),
        .din (rd_pipe_q[LAT]),
        .dout(read_data)
    );

endmodule

// File: tb/tb_data_memory_sync.sv
// Directed bench: a latency-2 clearing instance and a latency-1 non-clearing instance
// with a short (12-word) depth for the out-of-range address behaviour.
module tb_data_memory_sync;

    localparam int AW = 4;
    localparam int DW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic          rst_n, req_valid, write_enable, output_enable, debug_enable, debug_we;
    logic [AW-1:0] data_addr, debug_addr;
    logic [DW-1:0] write_data, debug_wdata, debug_rdata;
    logic          req_ready, read_valid, init_done;
    wire  [DW-1:0] read_data;

    logic          b_rst_n, b_req_valid, b_we, b_oe, b_dbg_en, b_dbg_we;
    logic [AW-1:0] b_addr, b_dbg_addr;
    logic [DW-1:0] b_wdata, b_dbg_wdata, b_dbg_rdata;
    logic          b_req_ready, b_read_valid, b_init_done;
    wire  [DW-1:0] b_read_data;

    data_memory_sync #(
        .D_ADDR_W(AW), .DATA_W(DW), .D_MEMORY_DEPTH(16), .READ_LATENCY(2), .CLEAR_ON_RESET(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .data_addr(data_addr), .write_enable(write_enable), .write_data(write_data),
        .output_enable(output_enable), .read_data(read_data), .read_valid(read_valid),
        .debug_enable(debug_enable), .debug_addr(debug_addr), .debug_we(debug_we),
        .debug_wdata(debug_wdata), .debug_rdata(debug_rdata), .init_done(init_done)
    );

    data_memory_sync #(
        .D_ADDR_W(AW), .DATA_W(DW), .D_MEMORY_DEPTH(12), .READ_LATENCY(1), .CLEAR_ON_RESET(0)
    ) dut_nc (
        .clk(clk), .rst_n(b_rst_n), .req_valid(b_req_valid), .req_ready(b_req_ready),
        .data_addr(b_addr), .write_enable(b_we), .write_data(b_wdata),
        .output_enable(b_oe), .read_data(b_read_data), .read_valid(b_read_valid),
        .debug_enable(b_dbg_en), .debug_addr(b_dbg_addr), .debug_we(b_dbg_we),
        .debug_wdata(b_dbg_wdata), .debug_rdata(b_dbg_rdata), .init_done(b_init_done)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic cpu(input logic v, input logic we, input logic oe,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid = v; write_enable = we; output_enable = oe; data_addr = a; write_data = d;
    endtask

    task automatic test_reset;
        logic [DW-1:0] zz;
        zz = {DW{1'bz}};
        rst_n = 1'b0;
        repeat (2) tick;
        n_cmp++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL rst_req_ready: got %b want 0", req_ready); end
        n_cmp++; if (init_done !== 1'b0) begin n_bad++; $display("FAIL rst_init_done: got %b want 0", init_done); end
        n_cmp++; if (read_valid !== 1'b0) begin n_bad++; $display("FAIL rst_read_valid: got %b want 0", read_valid); end
        n_cmp++; if (debug_rdata !== 8'h00) begin n_bad++; $display("FAIL rst_debug_rdata: got %h want 00", debug_rdata); end
        n_cmp++; if (read_data !== zz) begin n_bad++; $display("FAIL rst_read_data: got %h want z", read_data); end
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            n_cmp++; if (req_ready !== 1'b0 || init_done !== 1'b0) begin
                n_bad++; $display("FAIL sweep_busy[%0d]: got ready=%b done=%b want 0/0", i, req_ready, init_done);
            end
            tick;
        end
        n_cmp++; if (init_done !== 1'b1) begin n_bad++; $display("FAIL sweep_done: got %b want 1", init_done); end
        n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL sweep_ready: got %b want 1", req_ready); end
        // Back-to-back reads of every word; each answers one cycle after the next edge.
        for (int i = 0; i < 17; i++) begin
            if (i < 16) cpu(1, 0, 1, AW'(i), 8'h00); else cpu(0, 0, 0, 0, 8'h00);
            tick;
            n_cmp++; if (read_valid !== (i >= 1)) begin
                n_bad++; $display("FAIL clear_rv[%0d]: got %b want %b", i, read_valid, (i >= 1));
            end
            n_cmp++; if (read_data !== ((i >= 1) ? 8'h00 : zz)) begin
                n_bad++; $display("FAIL clear_rd[%0d]: got %h want %h", i, read_data, ((i >= 1) ? 8'h00 : zz));
            end
        end
        cpu(0, 0, 0, 0, 8'h00);
        tick;
        n_cmp++; if (read_valid !== 1'b0) begin n_bad++; $display("FAIL clear_tail_rv: got %b want 0", read_valid); end
    endtask

    task automatic test_write_read;
        logic          ev;
        logic [DW-1:0] ed;
        for (int i = 0; i < 6; i++) begin
            case (i)
                0:       cpu(1, 1, 0, 4'h3, 8'hA5);
                1:       cpu(1, 0, 1, 4'h3, 8'h00);
                3:       cpu(1, 0, 0, 4'h3, 8'h00);
                default: cpu(0, 0, 0, 4'h0, 8'h00);
            endcase
            tick;
            ev = (i == 2);
            ed = ev ? 8'hA5 : {DW{1'bz}};
            n_cmp++; if (read_valid !== ev) begin n_bad++; $display("FAIL wr_rd_rv[%0d]: got %b want %b", i, read_valid, ev); end
            n_cmp++; if (read_data !== ed) begin n_bad++; $display("FAIL wr_rd_data[%0d]: got %h want %h", i, read_data, ed); end
        end
    endtask

    task automatic test_back_to_back;
        logic          ev;
        logic [DW-1:0] ed;
        for (int i = 0; i < 8; i++) begin
            case (i)
                0:       cpu(1, 1, 0, 4'h0, 8'h11);
                1:       cpu(1, 1, 0, 4'h1, 8'h22);
                2:       cpu(1, 1, 0, 4'h2, 8'h33);
                3:       cpu(1, 0, 1, 4'h0, 8'h00);
                4:       cpu(1, 0, 1, 4'h1, 8'h00);
                5:       cpu(1, 0, 1, 4'h2, 8'h00);
                default: cpu(0, 0, 0, 4'h0, 8'h00);
            endcase
            tick;
            ev = (i >= 4 && i <= 6);
            case (i)
                4:       ed = 8'h11;
                5:       ed = 8'h22;
                6:       ed = 8'h33;
                default: ed = {DW{1'bz}};
            endcase
            n_cmp++; if (read_valid !== ev) begin n_bad++; $display("FAIL b2b_rv[%0d]: got %b want %b", i, read_valid, ev); end
            n_cmp++; if (read_data !== ed) begin n_bad++; $display("FAIL b2b_data[%0d]: got %h want %h", i, read_data, ed); end
        end
    endtask

    task automatic test_debug;
        // A read launched just before debug takes over must still complete.
        cpu(1, 0, 1, 4'h3, 8'h00);
        tick;
        debug_enable = 1'b1; debug_we = 1'b1; debug_addr = 4'h7; debug_wdata = 8'h5C;
        cpu(1, 1, 0, 4'h7, 8'hEE);
        #2;
        n_cmp++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL dbg_ready_wr: got %b want 0", req_ready); end
        tick;
        n_cmp++; if (read_valid !== 1'b1 || read_data !== 8'hA5) begin
            n_bad++; $display("FAIL dbg_inflight: got rv=%b data=%h want 1/a5", read_valid, read_data);
        end
        n_cmp++; if (debug_rdata !== 8'h00) begin n_bad++; $display("FAIL dbg_old_value: got %h want 00", debug_rdata); end
        debug_we = 1'b0;
        cpu(0, 0, 0, 4'h0, 8'h00);
        #2;
        n_cmp++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL dbg_ready_rd: got %b want 0", req_ready); end
        tick;
        n_cmp++; if (debug_rdata !== 8'h5C) begin n_bad++; $display("FAIL dbg_rdata: got %h want 5c", debug_rdata); end
        debug_enable = 1'b0;
        #2;
        n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL dbg_release_ready: got %b want 1", req_ready); end
        cpu(1, 0, 1, 4'h7, 8'h00);
        tick;
        cpu(0, 0, 0, 4'h0, 8'h00);
        tick;
        n_cmp++; if (read_valid !== 1'b1 || read_data !== 8'h5C) begin
            n_bad++; $display("FAIL dbg_cpu_read: got rv=%b data=%h want 1/5c", read_valid, read_data);
        end
    endtask

    task automatic test_reset_mid;
        logic          ev;
        logic [DW-1:0] ed;
        cpu(1, 1, 0, 4'h9, 8'hFF); tick;
        cpu(1, 1, 0, 4'hF, 8'hFF); tick;
        cpu(1, 0, 1, 4'h3, 8'h00); tick;
        cpu(0, 0, 0, 4'h0, 8'h00);
        rst_n = 1'b0;
        #1;
        n_cmp++; if (read_valid !== 1'b0 || req_ready !== 1'b0 || init_done !== 1'b0) begin
            n_bad++; $display("FAIL mid_rst_now: got rv=%b rdy=%b done=%b want 0/0/0", read_valid, req_ready, init_done);
        end
        n_cmp++; if (debug_rdata !== 8'h00) begin n_bad++; $display("FAIL mid_rst_dbg: got %h want 00", debug_rdata); end
        tick;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            n_cmp++; if (read_valid !== 1'b0 || req_ready !== 1'b0) begin
                n_bad++; $display("FAIL mid_sweep1[%0d]: got rv=%b rdy=%b want 0/0", i, read_valid, req_ready);
            end
            tick;
        end
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            n_cmp++; if (init_done !== 1'b0 || read_valid !== 1'b0) begin
                n_bad++; $display("FAIL mid_sweep2[%0d]: got done=%b rv=%b want 0/0", i, init_done, read_valid);
            end
            tick;
        end
        n_cmp++; if (init_done !== 1'b1) begin n_bad++; $display("FAIL mid_done: got %b want 1", init_done); end
        for (int i = 0; i < 4; i++) begin
            case (i)
                0:       cpu(1, 0, 1, 4'h9, 8'h00);
                1:       cpu(1, 0, 1, 4'hF, 8'h00);
                2:       cpu(1, 0, 1, 4'h3, 8'h00);
                default: cpu(0, 0, 0, 4'h0, 8'h00);
            endcase
            tick;
            ev = (i >= 1);
            ed = ev ? 8'h00 : {DW{1'bz}};
            n_cmp++; if (read_valid !== ev || read_data !== ed) begin
                n_bad++; $display("FAIL mid_cleared[%0d]: got rv=%b data=%h want %b/%h", i, read_valid, read_data, ev, ed);
            end
        end
    endtask

    task automatic test_no_clear;
        logic          ev;
        logic [DW-1:0] ed;
        n_cmp++; if (b_req_ready !== 1'b0 || b_init_done !== 1'b0) begin
            n_bad++; $display("FAIL nc_in_reset: got rdy=%b done=%b want 0/0", b_req_ready, b_init_done);
        end
        b_rst_n = 1'b1;
        #1;
        n_cmp++; if (b_req_ready !== 1'b1 || b_init_done !== 1'b1) begin
            n_bad++; $display("FAIL nc_first_cycle: got rdy=%b done=%b want 1/1", b_req_ready, b_init_done);
        end
        for (int i = 0; i < 5; i++) begin
            b_req_valid = (i < 4); b_wdata = 8'h00; b_oe = 1'b0; b_we = 1'b0;
            case (i)
                0:       begin b_we = 1'b1; b_addr = 4'h5; b_wdata = 8'h6B; end
                1:       begin b_oe = 1'b1; b_addr = 4'h5; end
                2:       begin b_we = 1'b1; b_addr = 4'hD; b_wdata = 8'h77; end
                3:       begin b_oe = 1'b1; b_addr = 4'hD; end
                default: b_addr = 4'h0;
            endcase
            tick;
            ev = (i == 1 || i == 3);
            ed = (i == 1) ? 8'h6B : (i == 3) ? 8'h00 : {DW{1'bz}};
            n_cmp++; if (b_read_valid !== ev || b_read_data !== ed) begin
                n_bad++; $display("FAIL nc_rw[%0d]: got rv=%b data=%h want %b/%h", i, b_read_valid, b_read_data, ev, ed);
            end
        end
        b_req_valid = 1'b0;
        b_dbg_en = 1'b1; b_dbg_addr = 4'h5;
        tick;
        n_cmp++; if (b_dbg_rdata !== 8'h6B) begin n_bad++; $display("FAIL nc_dbg_rd: got %h want 6b", b_dbg_rdata); end
        b_dbg_addr = 4'hE;
        tick;
        n_cmp++; if (b_dbg_rdata !== 8'h00) begin n_bad++; $display("FAIL nc_dbg_oor: got %h want 00", b_dbg_rdata); end
        b_dbg_en = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; debug_enable = 1'b0; debug_we = 1'b0; debug_addr = '0; debug_wdata = '0;
        cpu(0, 0, 0, 4'h0, 8'h00);
        b_rst_n = 1'b0; b_req_valid = 1'b0; b_we = 1'b0; b_oe = 1'b0; b_addr = '0; b_wdata = '0;
        b_dbg_en = 1'b0; b_dbg_we = 1'b0; b_dbg_addr = '0; b_dbg_wdata = '0;
        test_reset;
        test_write_read;
        test_back_to_back;
        test_debug;
        test_reset_mid;
        test_no_clear;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
